// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - 8-bit request sequencer driving a 4-bit combinational ALU
//
// Splits each 8-bit request into a low-nibble pass and a high-nibble pass, then
// adds a +1/-1 fix-up pass on the high nibble when the low pass carried or
// borrowed. One request in flight; one response per request.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_op[2:0], req_a, req_b    operation (ALU sel encoding) and 8-bit operands
//   rsp_valid/rsp_ready          response handshake
//   rsp_result[7:0]              8-bit result
//   rsp_flag                     carry-out (add) / borrow-out (sub), else 0
//   rsp_err                      illegal op (101, 110, 111)
//   alu_a, alu_b, alu_sel        registered drive to the external ALU
//   alu_result, alu_carry,       combinational ALU response to the current drive
//   alu_borrow
module alu_nibble_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_flag,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_borrow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIX,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] SEL_IDLE = 3'b111;

  state_t     state, state_nx;
  logic [2:0] op;
  logic [3:0] a_hi, b_hi;
  logic [7:0] res;
  logic       c0, c1, c2, err;
  logic       accept, legal_req, alu_flag, rsp_done;
  logic [3:0] alu_a_nx, alu_b_nx;
  logic [2:0] alu_sel_nx;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign legal_req = (req_op <= 3'b100);
  assign rsp_done  = rsp_valid && rsp_ready;

  // Flags are only meaningful for the select that produces them; anything
  // the ALU reports during logic ops is discarded here.
  always_comb begin
    alu_flag = 1'b0;
    if (op == OP_ADD)      alu_flag = alu_carry;
    else if (op == OP_SUB) alu_flag = alu_borrow;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = legal_req ? S_LO : S_RESP;
      S_LO:   state_nx = S_HI;
      S_HI:   state_nx = ((op == OP_ADD || op == OP_SUB) && c0) ? S_FIX : S_RESP;
      S_FIX:  state_nx = S_RESP;
      S_RESP: if (rsp_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALU drive is registered from the next state so each pass has its
  // operands stable for the whole cycle it occupies.
  always_comb begin
    alu_a_nx   = 4'h0;
    alu_b_nx   = 4'h0;
    alu_sel_nx = SEL_IDLE;
    case (state_nx)
      S_LO: begin
        alu_a_nx   = req_a[3:0];
        alu_b_nx   = req_b[3:0];
        alu_sel_nx = req_op;
      end
      S_HI: begin
        alu_a_nx   = a_hi;
        alu_b_nx   = b_hi;
        alu_sel_nx = op;
      end
      S_FIX: begin
        // High-nibble result is being captured on this same edge.
        alu_a_nx   = alu_result;
        alu_b_nx   = 4'h1;
        alu_sel_nx = op;
      end
      default: begin
        alu_a_nx   = 4'h0;
        alu_b_nx   = 4'h0;
        alu_sel_nx = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= 3'b000;
      a_hi       <= 4'h0;
      b_hi       <= 4'h0;
      res        <= 8'h00;
      c0         <= 1'b0;
      c1         <= 1'b0;
      c2         <= 1'b0;
      err        <= 1'b0;
      alu_a      <= 4'h0;
      alu_b      <= 4'h0;
      alu_sel    <= SEL_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_flag   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state   <= state_nx;
      alu_a   <= alu_a_nx;
      alu_b   <= alu_b_nx;
      alu_sel <= alu_sel_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op   <= req_op;
            a_hi <= req_a[7:4];
            b_hi <= req_b[7:4];
            res  <= 8'h00;
            c0   <= 1'b0;
            c1   <= 1'b0;
            c2   <= 1'b0;
            err  <= !legal_req;
          end
        end
        S_LO: begin
          res[3:0] <= alu_result;
          c0       <= alu_flag;
        end
        S_HI: begin
          res[7:4] <= alu_result;
          c1       <= alu_flag;
        end
        S_FIX: begin
          res[7:4] <= alu_result;
          c2       <= alu_flag;
        end
        S_RESP: begin
          // First RESP cycle loads the response registers; they then hold
          // untouched until the consumer takes them.
          if (!rsp_valid) begin
            rsp_valid  <= 1'b1;
            rsp_result <= res;
            rsp_flag   <= c1 | c2;
            rsp_err    <= err;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - self-checking bench for alu_nibble_seq with a behavioural 4-bit ALU
module tb_alu_nibble_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_flag;
  logic       rsp_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry, alu_borrow;
  logic [4:0] alu_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_nibble_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_borrow (alu_borrow)
  );

  // Behavioural 4-bit ALU. Flags for the wrong select carry junk on purpose.
  always_comb begin
    alu_result = 4'h0;
    alu_carry  = ^alu_a;
    alu_borrow = alu_b[0];
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_sel)
      3'b000: begin alu_result = alu_sum[3:0]; alu_carry = alu_sum[4]; end
      3'b001: begin alu_result = alu_a - alu_b; alu_borrow = (alu_a < alu_b); end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      default: alu_result = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Issue one request, follow it to its response, hold the response for
  // 'hold' cycles of backpressure, then complete the handshake.
  task automatic run_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [8:0]  s9;
    logic [7:0]  e_res;
    logic        e_flag, e_err, fix;
    logic [3:0]  hi_nofix;
    logic [10:0] e_alu;
    int          lat, cyc;
    e_err = 1'b0;
    e_flag = 1'b0;
    fix = 1'b0;
    hi_nofix = 4'h0;
    case (op)
      3'd0: begin
        s9 = {1'b0, a} + {1'b0, b};
        e_res = s9[7:0];
        e_flag = s9[8];
        fix = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
        hi_nofix = a[7:4] + b[7:4];
      end
      3'd1: begin
        e_res = a - b;
        e_flag = (a < b);
        fix = (a[3:0] < b[3:0]);
        hi_nofix = a[7:4] - b[7:4];
      end
      3'd2: e_res = a & b;
      3'd3: e_res = a | b;
      3'd4: e_res = a ^ b;
      default: begin e_res = 8'h00; e_err = 1'b1; end
    endcase
    lat = e_err ? 1 : (fix ? 4 : 3);

    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    chk("req_ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = 8'($urandom);
    req_b = 8'($urandom);

    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      if (e_err)          e_alu = {4'h0, 4'h0, 3'b111};
      else if (cyc == 0)  e_alu = {a[3:0], b[3:0], op};
      else if (cyc == 1)  e_alu = {a[7:4], b[7:4], op};
      else if (cyc == 2 && fix) e_alu = {hi_nofix, 4'h1, op};
      else                e_alu = {4'h0, 4'h0, 3'b111};
      chk("alu_drive", {alu_a, alu_b, alu_sel}, e_alu);
      chk("req_ready_busy", req_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_flag", rsp_flag, e_flag);
    chk("rsp_err", rsp_err, e_err);
    chk("alu_idle_in_resp", {alu_a, alu_b, alu_sel}, {4'h0, 4'h0, 3'b111});

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, e_res);
      chk("hold_flag", rsp_flag, e_flag);
      chk("hold_err", rsp_err, e_err);
      chk("hold_req_ready", req_ready, 0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("valid_after_handshake", rsp_valid, 0);
    chk("ready_after_handshake", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_a = 8'h00;
    req_b = 8'h00;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flag", rsp_flag, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_alu", {alu_a, alu_b, alu_sel}, {4'h0, 4'h0, 3'b111});
    chk("reset_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);

    run_req(3'b000, 8'hFF, 8'h01, 0);
    run_req(3'b001, 8'h00, 8'h01, 0);
    run_req(3'b001, 8'h10, 8'h01, 0);
    run_req(3'b000, 8'h12, 8'h34, 0);
    run_req(3'b100, 8'hA5, 8'h0F, 0);
    run_req(3'b011, 8'hF0, 8'h0F, 0);
    run_req(3'b110, 8'h01, 8'h01, 0);
    run_req(3'b000, 8'h8C, 8'h95, 10);
    run_req(3'b010, 8'h3C, 8'h5A, 0);

    // Reset during the HI pass of 0xFF + 0x01.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'b000;
    req_a = 8'hFF;
    req_b = 8'h01;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hi_pass_drive", {alu_a, alu_b, alu_sel}, {4'hF, 4'h0, 3'b000});
    rst = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("ready_during_rst", req_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu", {alu_a, alu_b, alu_sel}, {4'h0, 4'h0, 3'b111});
    chk("midrst_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    rsp_ready = 1'b0;
    run_req(3'b000, 8'hFF, 8'h01, 0);

    for (int i = 0; i < 40; i++) begin
      run_req(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Sequential 8-bit operation controller that issues commands to the team's 4-bit combinational `alu` and collects its results. It is the initiator side of the ALU interface: it drives `a`/`b`/`sel` and samples `result`/`carry`/`borrow`. It splits each 8-bit request into nibble passes and adds a carry/borrow fix-up pass when needed. Upstream logic hands it one request at a time over valid/ready and receives one response per request.

## Interface
- Parameters: none. Operand width is fixed at 8 bits and the ALU width at 4 bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request.
- `req_op` in 3: operation code, same encoding as ALU `sel`.
- `req_a` in 8: operand A.
- `req_b` in 8: operand B.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 8: 8-bit result.
- `rsp_flag` out 1: carry-out for op 000, borrow-out for op 001, 0 otherwise.
- `rsp_err` out 1: illegal op (101, 110, 111).
- `alu_a` out 4: ALU operand a.
- `alu_b` out 4: ALU operand b.
- `alu_sel` out 3: ALU select.
- `alu_result` in 4: ALU result, combinational from `alu_a`/`alu_b`/`alu_sel`.
- `alu_carry` in 1: ALU carry. Valid only when `alu_sel`=000.
- `alu_borrow` in 1: ALU borrow. Valid only when `alu_sel`=001.

## Operation
- **Legal ops:** 000 add, 001 sub, 010 AND, 011 OR, 100 XOR.
  - 101, 110, 111 are illegal. They perform no ALU pass and give a response with `rsp_err`=1, `rsp_result`=0, `rsp_flag`=0.
- **FSM states:** IDLE, LO, HI, FIX, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch op/a/b and clear the internal flags c0, c1, c2.
  - Next state: LO for a legal op, RESP for an illegal op.
- **LO:**
  - Drive `alu_a`=a[3:0], `alu_b`=b[3:0], `alu_sel`=op.
  - Capture res[3:0]=`alu_result`.
  - c0 = `alu_carry` for op 000, `alu_borrow` for op 001, else 0.
  - Next state: HI.
- **HI:**
  - Drive a[7:4], b[7:4], op.
  - Capture res[7:4] and c1 (same rule as c0).
  - Next state: FIX if (op ∈ {000, 001} && c0=1), else RESP.
- **FIX:**
  - Drive `alu_a`=res[7:4], `alu_b`=4'b0001, `alu_sel`=op.
  - Capture res[7:4]=`alu_result` and c2 (carry for 000, borrow for 001).
  - Next state: RESP.
- **RESP:**
  - `rsp_valid`=1.
  - `rsp_result`=res; `rsp_flag`=c1|c2; `rsp_err` as latched.
  - All `rsp_*` outputs are held stable until `rsp_ready`=1. Then go to IDLE.
- **Idle ALU drive:** in IDLE and RESP, drive `alu_a`=0, `alu_b`=0, `alu_sel`=3'b111, so the ALU default output is 0.
- **Flag uniqueness:** c1 and c2 are never both 1. The flag OR is exact 8-bit carry/borrow.
- **Sampling rule:** ALU flags are sampled only in the state whose `alu_sel` makes them valid. Stale flags from logic ops are ignored.

## Timing
- **Reset** (`rst` high at a rising edge):
  - State goes to IDLE; any in-flight operation is discarded with no response.
  - Registered outputs after that edge: `rsp_valid`=0, `rsp_result`=0, `rsp_flag`=0, `rsp_err`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=3'b111.
  - `req_ready`=(state==IDLE)&&!`rst`, so it reads 0 while `rst` is high.
- **Latency:** request accepted at edge T.
  - LO occupies cycle T+1 and HI occupies T+2.
  - `rsp_valid` rises after edge T+3 with no fix-up, or after T+4 with fix-up.
  - Illegal op: `rsp_valid` rises after edge T+1.
- **Throughput:** one request in flight. `req_ready`=0 from the cycle after acceptance until the cycle after response handshake.
- **Response backpressure:** `rsp_ready` may stay low indefinitely. Outputs must not change while `rsp_valid`=1 and `rsp_ready`=0.
- **Back-to-back:** a response handshake at edge N returns to IDLE, and a new request can be accepted at edge N+1.
- **Request-side rules:** `req_*` are ignored outside IDLE. Operand changes after acceptance do not affect the result.

## Test plan
- **Add with fix-up:** op 000, A=0xFF, B=0x01, `rsp_ready`=1.
  - Expected: `rsp_result`=0x00, `rsp_flag`=1, `rsp_err`=0.
  - `rsp_valid` rises 4 cycles after acceptance; ALU sees sel 000 with (F,1), (F,0), then (F,1).
- **Sub, both fix-up outcomes:**
  - A=0x00, B=0x01 → `rsp_result`=0xFF, `rsp_flag`=1.
  - A=0x10, B=0x01 → `rsp_result`=0x0F, `rsp_flag`=0.
  - Both take the 4-cycle path.
- **No fix-up and logic ops:**
  - Add 0x12+0x34 → 0x46, flag 0, 3-cycle latency.
  - XOR 0xA5^0x0F → 0xAA, flag 0.
  - OR 0xF0|0x0F → 0xFF.
- **Illegal op:** op 110, A=0x01, B=0x01.
  - Expected: `rsp_err`=1, `rsp_result`=0, `rsp_valid` rises 1 cycle after acceptance, `alu_sel` stays 111 throughout.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles during a response.
  - Expected: response stable and `req_ready`=0 throughout; after the handshake edge, a new request is accepted on the next edge.
- **Reset mid-operation:** assert `rst` in the HI cycle of add 0xFF+0x01.
  - Expected: next edge returns to IDLE with `rsp_valid`=0, `alu_sel`=111, no response emitted.
  - The subsequent request completes correctly.
